// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared MIPS defines for the register-file writeback path.
// Holds the register-index width, the data width, the default starvation
// limit and the round-robin side encoding used by the arbiter and its
// LD/MD sub-arbiter.
package regfile_wb_arbiter_pkg;

  localparam int REG_W            = 5;
  localparam int DATA_W           = 32;
  localparam int NUM_REGS         = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  // Which of the two low-priority sources wins the next LD/MD tie.
  typedef enum logic {
    RR_LD = 1'b0,
    RR_MD = 1'b1
  } rr_side_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// wb_rr_arb2: two-request round-robin arbiter for the LD and MD writeback
// sources.
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   req_ld_i       LD request (already masked by ALU priority and reset)
//   req_md_i       MD request (already masked by ALU priority and reset)
//   gnt_ld_o       combinational LD grant
//   gnt_md_o       combinational MD grant
// The pointer names the side that wins a tie; after any grant it moves to
// the side that did not get the grant.
module wb_rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_ld_i,
  input  logic req_md_i,
  output logic gnt_ld_o,
  output logic gnt_md_o
);

  rr_side_e ptr_q;
  rr_side_e ptr_d;

  // Grant selection and pointer next state.
  always_comb begin
    gnt_ld_o = 1'b0;
    gnt_md_o = 1'b0;
    ptr_d    = ptr_q;
    if (req_ld_i && req_md_i) begin
      if (ptr_q == RR_LD) begin
        gnt_ld_o = 1'b1;
      end else begin
        gnt_md_o = 1'b1;
      end
    end else if (req_ld_i) begin
      gnt_ld_o = 1'b1;
    end else if (req_md_i) begin
      gnt_md_o = 1'b1;
    end else begin
      gnt_ld_o = 1'b0;
    end
    if (gnt_ld_o) begin
      ptr_d = RR_MD;
    end else if (gnt_md_o) begin
      ptr_d = RR_LD;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= RR_LD;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU, load-return and mul/div results onto the
// single register-file write port and tracks registers awaiting mul/div.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data    ALU result, always accepted (top priority)
//   ld_valid/ld_rd/ld_data,ld_ready  load-return handshake
//   md_valid/md_rd/md_data,md_ready  mul/div result handshake
//   md_issue/md_issue_rd         marks a register as awaiting a mul/div result
//   rs_num/rt_num, hazard        decode sources, pending-source indication
//   stall_req                    asks upstream to hold off ALU results
//   rd_we/rd_num/rd_data         registered write port (1 cycle after accept)
//   idle                         nothing pending and no write in flight
//   proto_err                    sticky: ALU result offered during stall_req
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  input  logic [REG_W-1:0]  ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              md_valid,
  input  logic [REG_W-1:0]  md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  input  logic              md_issue,
  input  logic [REG_W-1:0]  md_issue_rd,
  input  logic [REG_W-1:0]  rs_num,
  input  logic [REG_W-1:0]  rt_num,
  output logic              hazard,
  output logic              stall_req,
  output logic              rd_we,
  output logic [REG_W-1:0]  rd_num,
  output logic [DATA_W-1:0] rd_data,
  output logic              idle,
  output logic              proto_err
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic                req_ld_s, req_md_s;
  logic                ld_gnt_s, md_gnt_s, alu_gnt_s, accept_s;
  logic [REG_W-1:0]    sel_rd_s;
  logic [DATA_W-1:0]   sel_data_s;

  logic                rd_we_q, rd_we_d;
  logic [REG_W-1:0]    rd_num_q, rd_num_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                stall_q, stall_d;
  logic                perr_q, perr_d;

  // Reset and ALU priority are folded into the requests so the sub-arbiter
  // never grants (or moves its pointer) in those cycles.
  always_comb begin
    alu_gnt_s = alu_valid && !rst;
    req_ld_s  = ld_valid && !alu_valid && !rst;
    req_md_s  = md_valid && !alu_valid && !rst;
  end

  wb_rr_arb2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_ld_i (req_ld_s),
    .req_md_i (req_md_s),
    .gnt_ld_o (ld_gnt_s),
    .gnt_md_o (md_gnt_s)
  );

  // Select the winning request's destination and data.
  always_comb begin
    accept_s   = alu_gnt_s || ld_gnt_s || md_gnt_s;
    sel_rd_s   = alu_rd;
    sel_data_s = alu_data;
    if (alu_gnt_s) begin
      sel_rd_s   = alu_rd;
      sel_data_s = alu_data;
    end else if (ld_gnt_s) begin
      sel_rd_s   = ld_rd;
      sel_data_s = ld_data;
    end else if (md_gnt_s) begin
      sel_rd_s   = md_rd;
      sel_data_s = md_data;
    end else begin
      sel_rd_s   = alu_rd;
      sel_data_s = alu_data;
    end
  end

  // Next state for write port, busy vector, starve counter and flags.
  always_comb begin
    // r0 writes are consumed but never reach the regfile.
    rd_we_d   = accept_s && (sel_rd_s != REG_W'(0));
    rd_num_d  = rd_num_q;
    rd_data_d = rd_data_q;
    if (accept_s) begin
      rd_num_d  = sel_rd_s;
      rd_data_d = sel_data_s;
    end else begin
      rd_num_d  = rd_num_q;
      rd_data_d = rd_data_q;
    end

    // Clear first, then set, so a coinciding issue keeps the register busy.
    busy_d = busy_q;
    if (md_gnt_s) begin
      busy_d[md_rd] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (md_issue && (md_issue_rd != REG_W'(0))) begin
      busy_d[md_issue_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end

    cnt_d = cnt_q;
    if (ld_gnt_s || md_gnt_s || !(ld_valid || md_valid)) begin
      cnt_d = CNT_W'(0);
    end else if (alu_valid && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Counter clears on an LD/MD grant, which drops stall the cycle after.
    stall_d = (cnt_d == CNT_MAX);
    perr_d  = perr_q || (alu_valid && stall_q);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_we_q   <= 1'b0;
      rd_num_q  <= REG_W'(0);
      rd_data_q <= DATA_W'(0);
      busy_q    <= NUM_REGS'(0);
      cnt_q     <= CNT_W'(0);
      stall_q   <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      rd_we_q   <= rd_we_d;
      rd_num_q  <= rd_num_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      perr_q    <= perr_d;
    end
  end

  // Output drive: handshakes, hazard and idle are combinational.
  always_comb begin
    ld_ready  = ld_gnt_s;
    md_ready  = md_gnt_s;
    hazard    = ((rs_num != REG_W'(0)) && busy_q[rs_num]) ||
                ((rt_num != REG_W'(0)) && busy_q[rt_num]);
    idle      = (busy_q == NUM_REGS'(0)) && !rd_we_q;
    stall_req = stall_q;
    rd_we     = rd_we_q;
    rd_num    = rd_num_q;
    rd_data   = rd_data_q;
    proto_err = perr_q;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change 1 time unit after a
// rising edge, combinational outputs are checked 1 unit later, registered
// outputs right after the following edge.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, md_valid, md_issue;
  logic [4:0]  alu_rd, ld_rd, md_rd, md_issue_rd, rs_num, rt_num;
  logic [31:0] alu_data, ld_data, md_data;
  logic        ld_ready, md_ready, hazard, stall_req, rd_we, idle, proto_err;
  logic [4:0]  rd_num;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .rs_num(rs_num), .rt_num(rt_num), .hazard(hazard),
    .stall_req(stall_req), .rd_we(rd_we), .rd_num(rd_num), .rd_data(rd_data),
    .idle(idle), .proto_err(proto_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
    md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
    md_issue = 1'b0; md_issue_rd = 5'd0;
    rs_num = 5'd0; rt_num = 5'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset: ready held low even with a request offered.
    rst = 1'b1;
    clear_inputs();
    ld_valid = 1'b1; ld_rd = 5'd2; md_valid = 1'b1; md_rd = 5'd2;
    #1;
    check_eq("rst_ld_ready", ld_ready, 1'b0);
    check_eq("rst_md_ready", md_ready, 1'b0);
    tick();
    tick();
    check_eq("rst_rd_we", rd_we, 1'b0);
    check_eq("rst_rd_num", rd_num, 5'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    check_eq("rst_stall", stall_req, 1'b0);
    check_eq("rst_perr", proto_err, 1'b0);
    check_eq("rst_idle", idle, 1'b1);
    clear_inputs();
    rst = 1'b0;
    tick();

    // ALU beats LD; LD lands the cycle after.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
    ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h66;
    #1;
    check_eq("alu_pri_ld_ready", ld_ready, 1'b0);
    tick();
    check_eq("alu_wr_we", rd_we, 1'b1);
    check_eq("alu_wr_num", rd_num, 5'd5);
    check_eq("alu_wr_data", rd_data, 32'h11);
    alu_valid = 1'b0;
    #1;
    check_eq("ld_after_ready", ld_ready, 1'b1);
    tick();
    ld_valid = 1'b0;
    check_eq("ld_wr_we", rd_we, 1'b1);
    check_eq("ld_wr_num", rd_num, 5'd6);
    check_eq("ld_wr_data", rd_data, 32'h66);
    tick();
    check_eq("quiet_rd_we", rd_we, 1'b0);

    // LD/MD round robin from a fresh pointer: LD, MD, LD, MD.
    do_reset();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h7777;
    md_valid = 1'b1; md_rd = 5'd8; md_data = 32'h8888;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("rr_ld_ready", ld_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
      check_eq("rr_md_ready", md_ready, (i % 2 == 1) ? 1'b1 : 1'b0);
      tick();
      check_eq("rr_wr_we", rd_we, 1'b1);
      check_eq("rr_wr_num", rd_num, (i % 2 == 0) ? 5'd7 : 5'd8);
      check_eq("rr_wr_data", rd_data, (i % 2 == 0) ? 32'h7777 : 32'h8888);
    end
    clear_inputs();
    tick();

    // Busy tracking and hazard.
    md_issue = 1'b1; md_issue_rd = 5'd9;
    tick();
    md_issue = 1'b0;
    rs_num = 5'd9;
    #1;
    check_eq("haz_rs", hazard, 1'b1);
    check_eq("haz_idle", idle, 1'b0);
    rs_num = 5'd0; rt_num = 5'd9;
    #1;
    check_eq("haz_rt", hazard, 1'b1);
    rt_num = 5'd0;
    #1;
    check_eq("haz_r0", hazard, 1'b0);
    rs_num = 5'd9;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99;
    #1;
    check_eq("haz_md_ready", md_ready, 1'b1);
    check_eq("haz_held", hazard, 1'b1);
    tick();
    md_valid = 1'b0;
    #1;
    check_eq("haz_cleared", hazard, 1'b0);
    check_eq("md_wr_num", rd_num, 5'd9);
    check_eq("md_wr_data", rd_data, 32'h99);
    check_eq("idle_wr_busy", idle, 1'b0);
    tick();
    check_eq("idle_after", idle, 1'b1);
    rs_num = 5'd0;

    // Starvation: 4 losing cycles raise stall_req.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'hAA;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq("starve_stall", stall_req, (i == 4) ? 1'b1 : 1'b0);
    end
    alu_valid = 1'b0;
    #1;
    check_eq("starve_ld_ready", ld_ready, 1'b1);
    check_eq("starve_perr_clean", proto_err, 1'b0);
    tick();
    check_eq("starve_ld_num", rd_num, 5'd10);
    check_eq("starve_ld_data", rd_data, 32'hAA);
    check_eq("starve_stall_drop", stall_req, 1'b0);
    alu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    check_eq("stall_again", stall_req, 1'b1);
    check_eq("perr_not_yet", proto_err, 1'b0);
    tick();
    check_eq("perr_set", proto_err, 1'b1);
    clear_inputs();
    tick();
    tick();
    check_eq("perr_sticky", proto_err, 1'b1);
    check_eq("stall_idle", stall_req, 1'b0);

    // Set wins over clear; r0 consumed silently; reset mid-stream.
    do_reset();
    check_eq("rst_perr_clear", proto_err, 1'b0);
    md_issue = 1'b1; md_issue_rd = 5'd3;
    tick();
    md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h33;
    #1;
    check_eq("coinc_md_ready", md_ready, 1'b1);
    tick();
    clear_inputs();
    rs_num = 5'd3;
    #1;
    check_eq("coinc_busy", hazard, 1'b1);
    check_eq("coinc_wr_num", rd_num, 5'd3);
    check_eq("coinc_idle", idle, 1'b0);
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
    #1;
    check_eq("r0_ld_ready", ld_ready, 1'b1);
    tick();
    ld_valid = 1'b0;
    check_eq("r0_no_write", rd_we, 1'b0);
    alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'hE;
    tick();
    check_eq("inflight_we", rd_we, 1'b1);
    rst = 1'b1;
    ld_valid = 1'b1; ld_rd = 5'd13;
    md_valid = 1'b1; md_rd = 5'd13;
    md_issue = 1'b1; md_issue_rd = 5'd20;
    #1;
    check_eq("midrst_ld_ready", ld_ready, 1'b0);
    check_eq("midrst_md_ready", md_ready, 1'b0);
    tick();
    check_eq("midrst_rd_we", rd_we, 1'b0);
    check_eq("midrst_rd_num", rd_num, 5'd0);
    check_eq("midrst_rd_data", rd_data, 32'd0);
    check_eq("midrst_stall", stall_req, 1'b0);
    check_eq("midrst_perr", proto_err, 1'b0);
    check_eq("midrst_idle", idle, 1'b1);
    check_eq("midrst_hazard", hazard, 1'b0);
    rst = 1'b0;
    clear_inputs();
    rs_num = 5'd20;
    #1;
    check_eq("midrst_no_issue", hazard, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive cycles a waiting LD/MD request may lose to the ALU before stall_req asserts.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port alu_valid/alu_rd/alu_data  in  1/5/32  ALU writeback request; it has no ready and is always accepted.
REQ-005 SHALL have port ld_valid/ld_rd/ld_data  in  1/5/32, with ld_ready  out  1; this is the load-return request.
REQ-006 SHALL have port md_valid/md_rd/md_data  in  1/5/32, with md_ready  out  1; this is the mul/div result request.
REQ-007 SHALL have port md_issue/md_issue_rd  in  1/5  marking md_issue_rd as pending a mul/div result.
REQ-008 SHALL have port rs_num/rt_num  in  5/5  decode source registers.
REQ-009 SHALL have port hazard  out  1  meaning a decode source is pending.
REQ-010 SHALL have port stall_req  out  1  asking upstream to withhold alu_valid.
REQ-011 SHALL have port rd_we/rd_num/rd_data  out  1/5/32  single regfile write port, registered.
REQ-012 SHALL have port idle  out  1  meaning no pending registers and no write in flight.
REQ-013 SHALL have port proto_err  out  1  sticky protocol-violation flag.

Function
REQ-014 SHALL grant at most one request per cycle; a request is accepted when it is granted, and for LD/MD the accepting cycle is the one with valid&&ready.
REQ-015 SHALL give priority ALU > {LD, MD}; the LD/MD tie SHALL be broken round-robin by a 1-bit pointer that flips to the loser after each LD or MD grant (reset pointer = LD).
REQ-016 ld_ready/md_ready SHALL be combinational grant indications: 0 whenever alu_valid=1, otherwise per REQ-015.
REQ-017 SHALL present an accepted request on rd_we/rd_num/rd_data exactly 1 cycle after acceptance; rd_we=0 in cycles following no acceptance.
REQ-018 SHALL consume an accepted request with rd=0 without a write: rd_we stays 0, and the handshake still completes.
REQ-019 SHALL keep a 32-bit busy vector: md_issue with md_issue_rd!=0 sets busy[md_issue_rd] at the next edge.
REQ-020 an accepted MD request SHALL clear busy[md_rd] at the next edge; when set and clear of the same register coincide, set SHALL win.
REQ-021 md_issue to an already-busy register SHALL leave the register busy and SHALL NOT error.
REQ-022 hazard SHALL be combinational: (rs_num!=0 && busy[rs_num]) || (rt_num!=0 && busy[rt_num]).
REQ-023 SHALL keep a starve counter, saturating at STARVE_LIMIT: it increments each cycle (ld_valid||md_valid) && alu_valid, and clears on any LD/MD grant or when no LD/MD is valid.
REQ-024 stall_req SHALL be registered, and SHALL be 1 in the cycle after the counter reaches STARVE_LIMIT until an LD/MD grant occurs.
REQ-025 alu_valid=1 while stall_req=1 SHALL still grant the ALU and SHALL set proto_err, which stays 1 until reset.
REQ-026 idle SHALL be combinational: (busy==0) && !rd_we.

Reset
REQ-027 on rst=1 at a clock edge: busy=0, RR pointer=LD, starve counter=0, stall_req=0, rd_we=0, rd_num=0, rd_data=0, proto_err=0.
REQ-028 SHALL give reset priority over every simultaneous handshake and md_issue; a request offered during reset SHALL NOT be accepted, and a transaction in flight is discarded.
REQ-029 ld_ready and md_ready SHALL be 0 while rst=1.

Structure
REQ-030 the STARVE_LIMIT default, the register-index width (5) and the data width (32) SHALL reside in the shared MIPS defines header.
REQ-031 the LD/MD round-robin choice SHALL be one sub-module, wb_rr_arb2 (two requests, grant, pointer update).

Verification
REQ-032 ALU rd=5 data=0x11 alongside LD rd=6 -> cycle+1 rd_we=1 num=5 data=0x11, ld_ready=0, then LD num=6 written the next cycle.
REQ-033 LD and MD both valid continuously, no ALU -> writes alternate LD, MD, LD, MD, each 1 cycle after its ready.
REQ-034 md_issue rd=9, then rs_num=9 -> hazard=1 until MD rd=9 is accepted; hazard=0 the cycle after; idle=1 the cycle after the write.
REQ-035 alu_valid held high with ld_valid, STARVE_LIMIT=4 -> stall_req=1 after 4 losing cycles; upstream drops alu_valid -> LD written, stall_req=0; alu_valid during stall_req -> proto_err=1 sticky.
REQ-036 md_issue rd=3 coinciding with MD write rd=3 -> busy[3]=1; LD with rd=0 -> handshake completes, rd_we=0; rst mid-stream -> all outputs at REQ-027 values the next cycle.
